imem_ld_arbiter: RTL and testbench

//  Sequences the single port of the loadable instruction memory (9-bit line addr, 4-insn line).

---
 rtl/imem_ld_arbiter.sv | 120 ++++++++++++
 tb/tb_imem_ld_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_ld_arbiter.sv
// imem_ld_arbiter
//   Arbitrates the single port of the loadable instruction memory between the
//   fetch unit (line reads) and the program loader (line writes). One memory
//   op per cycle, loader has priority, and a fetch is forced through after
//   WR_BURST_MAX consecutive loader wins. ld_lock hands the port exclusively
//   to the loader for bulk program load.
// Ports
//   clk, reset_n                   clock / async active-low reset
//   fetch_req/addr/flush           fetch read request, address, kill
//   fetch_gnt/rvalid/rdata         read issued / data valid next cycle / line
//   ld_valid/addr/wdata, ld_ready  loader write handshake
//   ld_lock, locked                exclusive loader ownership request / status
//   mem_addr/wdata/we, mem_rdata   memory port (1-cycle read, read-before-write)

`ifndef INSN_LEN
`define INSN_LEN 32
`endif

module imem_ld_arbiter #(
  parameter int unsigned ADDR_W       = 9,
  parameter int unsigned DATA_W       = 4*`INSN_LEN,
  parameter int unsigned WR_BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  input  logic              fetch_flush,
  output logic              fetch_gnt,
  output logic              fetch_rvalid,
  output logic [DATA_W-1:0] fetch_rdata,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_ready,
  input  logic              ld_lock,
  output logic              locked,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = $clog2(WR_BURST_MAX + 1);

  typedef enum logic [1:0] {
    WAKE   = 2'd0,
    RUN    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic             rd_pend_q, rd_pend_d;

  logic fetch_ok;
  logic burst_full;

  assign fetch_ok   = fetch_req & ~fetch_flush;
  assign burst_full = (wr_cnt_q == CNT_W'(WR_BURST_MAX));

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = '0;
    fetch_gnt = 1'b0;
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;

    unique case (state_q)
      WAKE: begin
        state_d = RUN;
      end
      RUN: begin
        // Lock request only moves the state; this cycle still arbitrates as RUN.
        if (ld_lock) state_d = LOCKED;
        mem_addr = fetch_addr;
        if (ld_valid && !(fetch_ok && burst_full)) begin
          ld_ready = 1'b1;
          mem_we   = 1'b1;
          mem_addr = ld_addr;
          // Count only writes that made a live fetch wait; burst_full is
          // false here whenever fetch_ok, so the increment cannot overflow.
          if (fetch_ok) wr_cnt_d = wr_cnt_q + 1'b1;
        end else if (fetch_ok) begin
          fetch_gnt = 1'b1;
        end
      end
      LOCKED: begin
        if (!ld_lock) state_d = RUN;
        ld_ready = ld_valid;
        mem_we   = ld_valid;
        mem_addr = ld_addr;
      end
      default: begin
        state_d = WAKE;
      end
    endcase

    rd_pend_d = fetch_gnt & ~fetch_flush;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= WAKE;
      wr_cnt_q  <= '0;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_pend_q <= rd_pend_d;
    end
  end

  assign fetch_rvalid = rd_pend_q;
  assign fetch_rdata  = mem_rdata;
  assign mem_wdata    = ld_wdata;
  assign locked       = (state_q == LOCKED);

endmodule

// File: tb/tb_imem_ld_arbiter.sv
module tb_imem_ld_arbiter;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned DATA_W = 128;

  logic              clk;
  logic              reset_n;
  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_flush;
  logic              fetch_gnt;
  logic              fetch_rvalid;
  logic [DATA_W-1:0] fetch_rdata;
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_ready;
  logic              ld_lock;
  logic              locked;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;

  imem_ld_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .WR_BURST_MAX(4)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_flush (fetch_flush),
    .fetch_gnt   (fetch_gnt),
    .fetch_rvalid(fetch_rvalid),
    .fetch_rdata (fetch_rdata),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_wdata    (ld_wdata),
    .ld_ready    (ld_ready),
    .ld_lock     (ld_lock),
    .locked      (locked),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_we      (mem_we),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Initial line content: address embedded in every word.
  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
    return {4{7'h2B, a, 16'hC0DE}};
  endfunction

  // Memory model: 1-cycle read, read-before-write.
  logic [DATA_W-1:0] mem [512];
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = pat(ADDR_W'(i));
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      mem_rdata <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_wdata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic              freq;
    logic [ADDR_W-1:0] faddr;
    logic              flush;
    logic              lv;
    logic [ADDR_W-1:0] laddr;
    logic              lock;
    logic              e_gnt;
    logic              e_rdy;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic              e_rv;
    logic              e_lck;
  } vec_t;

  vec_t vecs[27];

  task automatic drive(input logic freq, input logic [ADDR_W-1:0] fa, input logic fl,
                       input logic lv, input logic [ADDR_W-1:0] la, input logic lk);
    fetch_req   = freq;
    fetch_addr  = fa;
    fetch_flush = fl;
    ld_valid    = lv;
    ld_addr     = la;
    ld_wdata    = {4{23'h6F5A00, la}};
    ld_lock     = lk;
  endtask

  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;
  int gnt_cnt, rdy_cnt, lck_cnt;
  logic [ADDR_W-1:0] prev_fa;

  initial begin
    //           freq faddr  fl lv laddr  lk  gnt rdy we addr   rv lck
    vecs[0]  = '{1, 9'h010, 0, 0, 9'h100, 0,  0, 0, 0, 9'h000, 0, 0}; // WAKE
    vecs[1]  = '{1, 9'h010, 0, 0, 9'h100, 0,  1, 0, 0, 9'h010, 0, 0};
    vecs[2]  = '{0, 9'h020, 0, 0, 9'h100, 0,  0, 0, 0, 9'h020, 1, 0};
    vecs[3]  = '{0, 9'h020, 0, 1, 9'h100, 0,  0, 1, 1, 9'h100, 0, 0};
    vecs[4]  = '{1, 9'h030, 0, 1, 9'h101, 0,  0, 1, 1, 9'h101, 0, 0}; // contention
    vecs[5]  = '{1, 9'h030, 0, 1, 9'h101, 0,  0, 1, 1, 9'h101, 0, 0};
    vecs[6]  = '{1, 9'h030, 0, 1, 9'h101, 0,  0, 1, 1, 9'h101, 0, 0};
    vecs[7]  = '{1, 9'h030, 0, 1, 9'h101, 0,  0, 1, 1, 9'h101, 0, 0};
    vecs[8]  = '{1, 9'h030, 0, 1, 9'h101, 0,  1, 0, 0, 9'h030, 0, 0};
    vecs[9]  = '{1, 9'h030, 0, 1, 9'h101, 0,  0, 1, 1, 9'h101, 1, 0};
    vecs[10] = '{1, 9'h030, 0, 1, 9'h101, 0,  0, 1, 1, 9'h101, 0, 0};
    vecs[11] = '{1, 9'h030, 0, 1, 9'h101, 0,  0, 1, 1, 9'h101, 0, 0};
    vecs[12] = '{1, 9'h030, 0, 1, 9'h101, 0,  0, 1, 1, 9'h101, 0, 0};
    vecs[13] = '{1, 9'h030, 0, 1, 9'h101, 0,  1, 0, 0, 9'h030, 0, 0};
    vecs[14] = '{0, 9'h040, 0, 0, 9'h101, 0,  0, 0, 0, 9'h040, 1, 0};
    vecs[15] = '{1, 9'h050, 1, 0, 9'h101, 0,  0, 0, 0, 9'h050, 0, 0}; // flush blocks
    vecs[16] = '{0, 9'h060, 0, 0, 9'h101, 0,  0, 0, 0, 9'h060, 0, 0};
    vecs[17] = '{1, 9'h070, 0, 0, 9'h101, 0,  1, 0, 0, 9'h070, 0, 0};
    vecs[18] = '{1, 9'h070, 1, 0, 9'h101, 0,  0, 0, 0, 9'h070, 1, 0}; // rvalid kept
    vecs[19] = '{0, 9'h070, 0, 0, 9'h101, 0,  0, 0, 0, 9'h070, 0, 0};
    vecs[20] = '{1, 9'h080, 0, 0, 9'h101, 1,  1, 0, 0, 9'h080, 0, 0}; // lock rises
    vecs[21] = '{1, 9'h080, 0, 1, 9'h102, 1,  0, 1, 1, 9'h102, 1, 1};
    vecs[22] = '{1, 9'h080, 0, 0, 9'h103, 1,  0, 0, 0, 9'h103, 0, 1};
    vecs[23] = '{1, 9'h090, 0, 1, 9'h104, 0,  0, 1, 1, 9'h104, 0, 1};
    vecs[24] = '{1, 9'h090, 0, 1, 9'h105, 0,  0, 1, 1, 9'h105, 0, 0};
    vecs[25] = '{1, 9'h090, 0, 0, 9'h105, 0,  1, 0, 0, 9'h090, 0, 0};
    vecs[26] = '{0, 9'h090, 0, 0, 9'h105, 0,  0, 0, 0, 9'h090, 1, 0};

    // Reset with both requesters active.
    reset_n = 1'b0;
    drive(1, 9'h010, 0, 1, 9'h100, 0);
    #2;
    check("rst_gnt",    fetch_gnt,    0);
    check("rst_rvalid", fetch_rvalid, 0);
    check("rst_ready",  ld_ready,     0);
    check("rst_we",     mem_we,       0);
    check("rst_locked", locked,       0);
    check("rst_addr",   mem_addr,     0);
    repeat (2) @(posedge clk);

    prev_fa = '0;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      if (i == 0) reset_n = 1'b1;
      drive(vecs[i].freq, vecs[i].faddr, vecs[i].flush, vecs[i].lv, vecs[i].laddr, vecs[i].lock);
      #2;
      check($sformatf("v%0d_gnt", i),    fetch_gnt,    vecs[i].e_gnt);
      check($sformatf("v%0d_ready", i),  ld_ready,     vecs[i].e_rdy);
      check($sformatf("v%0d_we", i),     mem_we,       vecs[i].e_we);
      check($sformatf("v%0d_addr", i),   mem_addr,     vecs[i].e_addr);
      check($sformatf("v%0d_rvalid", i), fetch_rvalid, vecs[i].e_rv);
      check($sformatf("v%0d_locked", i), locked,       vecs[i].e_lck);
      if (vecs[i].e_rv) check($sformatf("v%0d_rdata", i), fetch_rdata, pat(prev_fa));
      prev_fa = vecs[i].faddr;
    end

    // Bulk load under lock: fetch is shut out for 100 cycles.
    @(negedge clk);
    drive(1, 9'h0A0, 0, 1, 9'h120, 1);
    #2;
    check("lk_enter_ready", ld_ready, 1);
    gnt_cnt = 0; rdy_cnt = 0; lck_cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      drive(1, 9'h0A0, 0, 1, ADDR_W'(9'h121 + i), 1);
      #2;
      gnt_cnt += int'(fetch_gnt);
      rdy_cnt += int'(ld_ready & mem_we);
      lck_cnt += int'(locked);
    end
    check("lk_gnt_cnt",   gnt_cnt, 0);
    check("lk_write_cnt", rdy_cnt, 100);
    check("lk_locked_cnt", lck_cnt, 100);
    @(negedge clk);
    drive(1, 9'h0A0, 0, 0, 9'h1F0, 0);
    #2;
    check("lk_drop_gnt",    fetch_gnt, 0);
    check("lk_drop_locked", locked,    1);
    @(negedge clk);
    #2;
    check("lk_run_gnt",    fetch_gnt, 1);
    check("lk_run_locked", locked,    0);
    check("lk_run_addr",   mem_addr,  9'h0A0);

    // Read after write to the top line.
    val_a = {4{32'hA5A5_0001}};
    @(negedge clk);
    drive(0, 9'h000, 0, 1, 9'h1FF, 0);
    ld_wdata = val_a;
    #2;
    check("raw_we",    mem_we,    1);
    check("raw_waddr", mem_addr,  9'h1FF);
    check("raw_wdata", mem_wdata, val_a);
    @(negedge clk);
    drive(1, 9'h1FF, 0, 0, 9'h000, 0);
    #2;
    check("raw_gnt", fetch_gnt, 1);
    @(negedge clk);
    drive(0, 9'h000, 0, 0, 9'h000, 0);
    #2;
    check("raw_rvalid", fetch_rvalid, 1);
    check("raw_rdata",  fetch_rdata,  val_a);

    // Reset while a read is pending: the return is dropped.
    val_b = {4{32'h5A5A_0002}};
    @(negedge clk);
    drive(0, 9'h000, 0, 1, 9'h1FF, 0);
    ld_wdata = val_b;
    @(negedge clk);
    drive(1, 9'h1FF, 0, 0, 9'h000, 0);
    #2;
    check("rr_gnt", fetch_gnt, 1);
    @(negedge clk);
    reset_n = 1'b0;
    drive(1, 9'h1FF, 0, 1, 9'h000, 0);
    #1;
    check("rr_rvalid_rst", fetch_rvalid, 0);
    check("rr_gnt_rst",    fetch_gnt,    0);
    check("rr_we_rst",     mem_we,       0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive(0, 9'h000, 0, 0, 9'h000, 0);
    #2;
    check("rr_rvalid_wake", fetch_rvalid, 0);
    @(negedge clk);
    #2;
    check("rr_rvalid_run", fetch_rvalid, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
